// File: rtl/spw_rx_seq_pkg.sv
// rtl/spw_rx_seq_pkg.sv - shared types and constants for the SpaceWire RX PIO sequencer
package spw_rx_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_POP  = 4'b0010,
    ST_LOAD = 4'b0100,
    ST_HOLD = 4'b1000
  } seq_state_t;

  localparam logic [7:0] SPW_EOP_CODE = 8'h00;
  localparam logic [7:0] SPW_EEP_CODE = 8'h01;
  localparam int         SPW_CTRL_BIT = 8;

  // True for an end-of-packet marker, normal (EOP) or error (EEP).
  function automatic logic is_packet_end(input logic [SPW_CTRL_BIT:0] chr);
    return chr[SPW_CTRL_BIT] &&
           ((chr[7:0] == SPW_EOP_CODE) || (chr[7:0] == SPW_EEP_CODE));
  endfunction

endpackage

// File: rtl/spw_rx_marker_counter.sv
// rtl/spw_rx_marker_counter.sv - wrapping count of EOP/EEP markers loaded into the PIO holding register
module spw_rx_marker_counter
  import spw_rx_seq_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic [15:0]       cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load && is_packet_end(data[SPW_CTRL_BIT:0])) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/spw_rx_pio_sequencer.sv
// rtl/spw_rx_pio_sequencer.sv - pops RX FIFO characters into a held PIO word released by an ack toggle
// Optional marker counter and eop_cnt port under `define SPW_RX_EOP_COUNT_EN.
module spw_rx_pio_sequencer
  import spw_rx_seq_pkg::*;
#(
  parameter int DATA_W         = 9,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_rd,
  input  logic              ack_toggle,
  input  logic              irq_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid,
  output logic              irq,
  output logic              ack_err,
  output logic              timeout_o
`ifdef SPW_RX_EOP_COUNT_EN
  ,
  output logic [15:0]       eop_cnt
`endif
);

  localparam logic [TIMEOUT_W-1:0] HOLD_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  seq_state_t           state;
  seq_state_t           state_next;
  logic                 load_en;
  logic                 ack_q;
  logic                 ack_edge;
  logic                 ack_err_set;
  logic                 timeout_set;
  logic [TIMEOUT_W-1:0] hold_cnt;

  assign ack_edge    = ack_toggle ^ ack_q;
  assign ack_err_set = ack_edge && (state != ST_HOLD);
  // The counter parks at the limit, so a stalled reader keeps re-asserting the flag.
  assign timeout_set = (state == ST_HOLD) && !ack_edge && (hold_cnt == HOLD_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rx_rd      = 1'b0;
    load_en    = 1'b0;
    case (state)
      ST_IDLE: if (!rx_empty) state_next = ST_POP;
      ST_POP: begin
        rx_rd      = 1'b1;
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        load_en    = 1'b1;
        state_next = ST_HOLD;
      end
      ST_HOLD: if (ack_edge) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_o     <= '0;
      data_valid <= 1'b0;
      irq        <= 1'b0;
      ack_q      <= 1'b0;
      hold_cnt   <= '0;
      ack_err    <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      ack_q <= ack_toggle;
      irq   <= data_valid & irq_en;

      if (load_en) begin
        data_o     <= rx_data;
        data_valid <= 1'b1;
        hold_cnt   <= '0;
      end else if (state == ST_HOLD) begin
        if (ack_edge) begin
          data_valid <= 1'b0;
        end else if (hold_cnt != HOLD_LIMIT) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end

      if (ack_err_set) begin
        ack_err <= 1'b1;
      end else if (clr_err) begin
        ack_err <= 1'b0;
      end

      if (timeout_set) begin
        timeout_o <= 1'b1;
      end else if (clr_err) begin
        timeout_o <= 1'b0;
      end
    end
  end

`ifdef SPW_RX_EOP_COUNT_EN
  spw_rx_marker_counter #(
    .DATA_W(DATA_W)
  ) u_marker_counter (
    .clk  (clk),
    .reset(reset),
    .load (load_en),
    .data (rx_data),
    .cnt  (eop_cnt)
  );
`endif

endmodule

// File: tb/tb_spw_rx_pio_sequencer.sv
// tb/tb_spw_rx_pio_sequencer.sv - scoreboard bench for the SpaceWire RX PIO sequencer
module tb_spw_rx_pio_sequencer;

  localparam int DATA_W = 9;
  localparam int TW     = 16;
  localparam int TC     = 8;

  logic              clk        = 1'b0;
  logic              reset      = 1'b1;
  logic              rx_empty   = 1'b1;
  logic [DATA_W-1:0] rx_data    = '0;
  logic              rx_rd;
  logic              ack_toggle = 1'b0;
  logic              irq_en     = 1'b0;
  logic              clr_err    = 1'b0;
  logic [DATA_W-1:0] data_o;
  logic              data_valid;
  logic              irq;
  logic              ack_err;
  logic              timeout_o;
`ifdef SPW_RX_EOP_COUNT_EN
  logic [15:0]       eop_cnt;
`endif

  spw_rx_pio_sequencer #(
    .DATA_W        (DATA_W),
    .TIMEOUT_W     (TW),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_empty  (rx_empty),
    .rx_data   (rx_data),
    .rx_rd     (rx_rd),
    .ack_toggle(ack_toggle),
    .irq_en    (irq_en),
    .clr_err   (clr_err),
    .data_o    (data_o),
    .data_valid(data_valid),
    .irq       (irq),
    .ack_err   (ack_err),
    .timeout_o (timeout_o)
`ifdef SPW_RX_EOP_COUNT_EN
    ,
    .eop_cnt   (eop_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  logic [8:0] fifo[$];
  logic [8:0] exp_q[$];
  int         n_pass    = 0;
  int         n_total   = 0;
  int         rd_count  = 0;
  int         eop_exp   = 0;
  bit         auto_ack  = 1'b0;
  int         ack_delay = 5;
  int         hold_cnt  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic bit is_marker(logic [8:0] c);
    return c[8] && (c[7:0] <= 8'h01);
  endfunction

  task automatic push(input logic [8:0] c);
    fifo.push_back(c);
    exp_q.push_back(c);
    if (is_marker(c)) eop_exp++;
    rx_empty = 1'b0;
  endtask

  // One cycle of the FIFO/PIO environment; read data follows the pop strobe.
  task automatic step();
    @(negedge clk);
    if (rx_rd) begin
      rd_count++;
      if (fifo.size() > 0) begin
        rx_data = fifo.pop_front();
      end else begin
        n_total++;
        $display("FAIL rd_on_empty: got rx_rd=1 expected no pop with FIFO empty");
      end
    end
    rx_empty = (fifo.size() == 0);
    if (auto_ack && data_valid) begin
      hold_cnt++;
      if (hold_cnt >= ack_delay) begin
        ack_toggle = ~ack_toggle;
        hold_cnt   = 0;
      end
    end else begin
      hold_cnt = 0;
    end
  endtask

  task automatic wait_dv();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (data_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_dv_bound", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (fifo.size() == 0 && exp_q.size() == 0 && !data_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_bound", {31'd0, ok}, 32'd1);
  endtask

  task automatic latency(input logic [8:0] c);
    push(c);
    step();
    check("lat_rd_k", {31'd0, rx_rd}, 32'd1);
    step();
    check("lat_rd_k1", {31'd0, rx_rd}, 32'd0);
    check("lat_dv_k1", {31'd0, data_valid}, 32'd0);
    step();
    check("lat_dv_k2", {31'd0, data_valid}, 32'd1);
    check("lat_data", {23'd0, data_o}, {23'd0, c});
    ack_toggle = ~ack_toggle;
    step();
    check("lat_ack_clear", {31'd0, data_valid}, 32'd0);
  endtask

  // Monitor: every rising data_valid consumes the next expected character.
  initial begin
    logic [8:0] cur_exp = '0;
    logic       dv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        dv_prev = 1'b0;
      end else begin
        if (data_valid && !dv_prev) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_unexpected: got data_o=0x%0h expected no character", data_o);
          end else begin
            cur_exp = exp_q.pop_front();
            check("sb_data", {23'd0, data_o}, {23'd0, cur_exp});
          end
        end else if (data_valid) begin
          check("sb_hold", {23'd0, data_o}, {23'd0, cur_exp});
        end
        dv_prev = data_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    int sent;
    bit done;
    logic [8:0] c;

    repeat (2) step();
    check("rst_data_o", {23'd0, data_o}, 32'd0);
    check("rst_dv", {31'd0, data_valid}, 32'd0);
    check("rst_rx_rd", {31'd0, rx_rd}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ack_err", {31'd0, ack_err}, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);
    reset = 1'b0;
    step();

    auto_ack  = 1'b1;
    ack_delay = 5;
    rd0 = rd_count;
    push(9'h041);
    push(9'h1A5);
    push(9'h100);
    drain(200);
    check("tp_rd_pulses", rd_count - rd0, 32'd3);
`ifdef SPW_RX_EOP_COUNT_EN
    check("tp_eop_cnt", {16'd0, eop_cnt}, eop_exp);
`endif

    auto_ack = 1'b0;
    latency(9'h0A7);

    push(9'h155);
    wait_dv();
    for (int i = 1; i <= 7; i++) begin
      step();
      check("to_early", {31'd0, timeout_o}, 32'd0);
    end
    step();
    check("to_set", {31'd0, timeout_o}, 32'd1);
    check("to_data", {23'd0, data_o}, 32'h155);
    repeat (3) step();
    check("to_still_valid", {31'd0, data_valid}, 32'd1);
    check("to_sticky", {31'd0, timeout_o}, 32'd1);
    ack_toggle = ~ack_toggle;
    step();
    check("to_ack_clear", {31'd0, data_valid}, 32'd0);
    auto_ack  = 1'b1;
    ack_delay = 2;
    rd0 = rd_count;
    push(9'h033);
    drain(100);
    check("to_resume_rd", rd_count - rd0, 32'd1);
    check("to_before_clr", {31'd0, timeout_o}, 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("to_clr", {31'd0, timeout_o}, 32'd0);

    auto_ack = 1'b0;
    rd0 = rd_count;
    ack_toggle = ~ack_toggle;
    step();
    check("ae_set", {31'd0, ack_err}, 32'd1);
    repeat (3) step();
    check("ae_no_rd", rd_count - rd0, 32'd0);
    clr_err    = 1'b1;
    ack_toggle = ~ack_toggle;
    step();
    clr_err = 1'b0;
    check("ae_set_wins", {31'd0, ack_err}, 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ae_clr", {31'd0, ack_err}, 32'd0);

    irq_en = 1'b1;
    push(9'h0C3);
    wait_dv();
    check("irq_lag0", {31'd0, irq}, 32'd0);
    step();
    check("irq_high", {31'd0, irq}, 32'd1);
    irq_en = 1'b0;
    step();
    check("irq_dis", {31'd0, irq}, 32'd0);
    ack_toggle = ~ack_toggle;
    step();
    check("irq_ack_clear", {31'd0, data_valid}, 32'd0);

    // Reset while the popped character sits in the LOAD cycle.
    irq_en     = 1'b1;
    ack_toggle = ~ack_toggle;
    step();
    push(9'h02E);
    step();
    step();
    reset      = 1'b1;
    ack_toggle = 1'b0;
    #1;
    check("rl_data_o", {23'd0, data_o}, 32'd0);
    check("rl_dv", {31'd0, data_valid}, 32'd0);
    check("rl_rx_rd", {31'd0, rx_rd}, 32'd0);
    check("rl_irq", {31'd0, irq}, 32'd0);
    check("rl_ack_err", {31'd0, ack_err}, 32'd0);
    check("rl_timeout", {31'd0, timeout_o}, 32'd0);
    void'(exp_q.pop_back());
    eop_exp = 0;
    step();
    step();
    reset = 1'b0;
`ifdef SPW_RX_EOP_COUNT_EN
    check("rl_eop_cnt", {16'd0, eop_cnt}, 32'd0);
`endif
    latency(9'h101);

    auto_ack = 1'b1;
    rd0  = rd_count;
    sent = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (sent >= 40 && exp_q.size() == 0 && fifo.size() == 0 && !data_valid) break;
      if (sent < 40 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0) c = {1'b1, 7'd0, 1'($urandom)};
        else c = 9'($urandom);
        push(c);
        sent++;
      end
      if (!data_valid) ack_delay = $urandom_range(1, 6);
      step();
    end
    done = (sent == 40) && (exp_q.size() == 0) && !data_valid;
    check("rnd_done", {31'd0, done}, 32'd1);
    check("rnd_rd_pulses", rd_count - rd0, 32'd40);
    check("rnd_ack_err", {31'd0, ack_err}, 32'd0);
    check("rnd_timeout", {31'd0, timeout_o}, 32'd0);
`ifdef SPW_RX_EOP_COUNT_EN
    check("rnd_eop_cnt", {16'd0, eop_cnt}, eop_exp);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
